ext_pipe: RTL
=============

# ext_pipe

Registered, handshaked successor to the single-cycle immediate extender. It sits between decode/memory-read and writeback. It applies one of eight extension modes (immediate zero/sign/upper, byte/half load extension with lane select, word pass-through) to a DATA_W-bit operand. Results are buffered in a 2-entry output queue so upstream and downstream stalls decouple without bubbles.

## Interface
- DATA_W, 32: operand/result width; multiple of 16, ≥32.
- OFF_W, log2(DATA_W/8): byte-offset width (derived; do not override).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept; high when queue holds <2 entries.
- in_data  in  DATA_W  raw operand (immediate in [15:0], or loaded word).
- in_mode  in  3  extension mode (see Operation).
- in_off  in  OFF_W  byte offset for LB/LBU/LH/LHU; ignored otherwise.
- out_valid  out  1  queue head valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_W  extended result.
- out_err  out  1  misaligned halfword flag for the head entry.

## Operation
- Modes, with b = byte at in_data[8*in_off +: 8] and h = half at in_data[16*in_off[OFF_W-1:1] +: 16]:
  - 0 ZEXT: zero-extend in_data[15:0].
  - 1 SEXT: sign-extend in_data[15:0] from bit 15.
  - 2 LUI: in_data[15:0] at bits [31:16], all other bits 0.
  - 3 LB: sign-extend b.
  - 4 LBU: zero-extend b.
  - 5 LH: sign-extend h.
  - 6 LHU: zero-extend h.
  - 7 WORD: in_data unchanged.
- Result and err are computed combinationally from the inputs and written into the queue on accept (in_valid & in_ready).
- Queue: 2 entries, FIFO order, count 0..2; the head drives out_data/out_err; out_valid = (count != 0).
- Count transitions:
  - accept only: +1.
  - pop (out_valid & out_ready) only: −1.
  - both in the same cycle: unchanged; head advances and the new entry lands at the tail.
- Full (count=2): in_ready=0, input is held upstream. Empty: out_valid=0, out_data holds its last value.
- Entries are never dropped or duplicated. Pointers wrap mod 2.
- Reset (any time, including mid-transfer): count=0, pointers=0, queued data discarded.
  - Reset values: out_valid=0, out_data=0, out_err=0, in_ready=1.
  - Accepts are ignored while rst_n is low.

## Timing
- Latency: accept at edge N → out_valid/out_data visible after edge N (cycle N+1).
- Throughput: 1 result/cycle while out_ready=1.
- in_ready depends only on registered count, never combinationally on out_ready.
- out_data/out_err are stable while out_valid=1 & out_ready=0.
- Reset assertion clears state asynchronously; deassertion is taken on clk.

## Configuration
- EXT_ERR_EN defined:
  - LH/LHU with in_off[0]=1 sets out_err=1 for that entry; data is still produced using the aligned half selected by in_off[OFF_W-1:1].
  - All other modes give err=0.
- EXT_ERR_EN undefined: err storage is removed and out_err is tied to 0. Data behaviour is identical.

## Test plan
- Reset mid-stream: fill queue with 2 entries, assert rst_n=0 → out_valid=0, out_data=0, in_ready=1 immediately. After release, no stale entries emerge.
- Immediate modes (DATA_W=32), in_data=0x0000_8001, out_ready=1:
  - mode0 → 0x0000_8001.
  - mode1 → 0xFFFF_8001.
  - mode2 → 0x8001_0000.
  - Each appears the cycle after accept.
- Load modes, in_data=0x80FF_7F01:
  - LB off=2 → 0x0000_00FF? No: b=0xFF → 0xFFFF_FFFF.
  - LBU off=3 → 0x0000_0080.
  - LH off=0 → 0x0000_7F01.
  - LHU off=2 → 0x0000_80FF.
  - LH off=2 → 0xFFFF_80FF.
  - WORD → 0x80FF_7F01.
- Backpressure: hold out_ready=0, offer 3 values → 2 accepted, in_ready=0 on the third. Raise out_ready → outputs appear in order, then the third is accepted.
- Simultaneous push/pop at count=1 for 10 cycles → count stays 1, in_ready stays 1, ordering preserved.
- With EXT_ERR_EN: LH off=1 → out_err=1, data from half 0. Without EXT_ERR_EN: same stimulus gives out_err=0.

Source files
------------

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate/load extender with a 2-entry output queue.
// Optional macro EXT_ERR_EN stores a misaligned-halfword flag per entry and drives out_err.
module ext_pipe #(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_mode,
  input  logic [OFF_W-1:0]  in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam logic [2:0] M_ZEXT = 3'd0;
  localparam logic [2:0] M_SEXT = 3'd1;
  localparam logic [2:0] M_LUI  = 3'd2;
  localparam logic [2:0] M_LB   = 3'd3;
  localparam logic [2:0] M_LBU  = 3'd4;
  localparam logic [2:0] M_LH   = 3'd5;
  localparam logic [2:0] M_LHU  = 3'd6;

  logic [DATA_W-1:0] mem [2];
  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              accept;
  logic              pop;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] res;

  // Handshake: a beat moves on a side only in a cycle where its valid and ready are both high.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Half select ignores in_off[0]; misalignment is only flagged, never corrected.
  assign byte_v = in_data[{in_off, 3'b000} +: 8];
  assign half_v = in_data[{in_off[OFF_W-1:1], 4'b0000} +: 16];

  always_comb begin
    res = '0;
    case (in_mode)
      M_ZEXT:  res = {{(DATA_W-16){1'b0}}, in_data[15:0]};
      M_SEXT:  res = {{(DATA_W-16){in_data[15]}}, in_data[15:0]};
      M_LUI:   res[31:16] = in_data[15:0];
      M_LB:    res = {{(DATA_W-8){byte_v[7]}}, byte_v};
      M_LBU:   res = {{(DATA_W-8){1'b0}}, byte_v};
      M_LH:    res = {{(DATA_W-16){half_v[15]}}, half_v};
      M_LHU:   res = {{(DATA_W-16){1'b0}}, half_v};
      default: res = in_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (accept) begin
      mem[wr_ptr] <= res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // When empty, the slot behind rd_ptr is the last entry popped, so the output holds.
  assign out_data = out_valid ? mem[rd_ptr] : mem[~rd_ptr];

`ifdef EXT_ERR_EN
  logic       err;
  logic [1:0] err_mem;

  assign err = in_off[0] & ((in_mode == M_LH) | (in_mode == M_LHU));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_mem <= 2'b00;
    end else if (accept) begin
      err_mem[wr_ptr] <= err;
    end
  end

  assign out_err = out_valid ? err_mem[rd_ptr] : err_mem[~rd_ptr];
`else
  assign out_err = 1'b0;
`endif

endmodule
